mem_port_arb: RTL

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/mem_port_arb.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_port_arb.sv
// Host/core arbiter onto one registered memory port: alternating priority on
// contention, one transfer per cycle, reads routed back to their owner two cycles later.
module mem_port_arb #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_h_valid,
  output logic              o_h_ready,
  input  logic [1:0]        i_h_op,
  input  logic [ADDR_W-1:0] i_h_addr,
  input  logic [DATA_W-1:0] i_h_wdata,
  output logic              o_h_rvalid,
  output logic [DATA_W-1:0] o_h_rdata,
  input  logic              i_c_valid,
  output logic              o_c_ready,
  input  logic [1:0]        i_c_op,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  output logic              o_c_rvalid,
  output logic [DATA_W-1:0] o_c_rdata,
  output logic [1:0]        o_mem_op,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);
  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  logic              last_core;
  logic              h_grant;
  logic              c_grant;
  logic              xfer;
  logic [1:0]        sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        mem_op_p0;
  logic [ADDR_W-1:0] mem_addr_p0;
  logic [DATA_W-1:0] mem_wdata_p0;
  logic              vld_p0;
  logic              vld_p1;
  logic              own_core_p0;
  logic              own_core_p1;
  logic [DATA_W-1:0] h_rdata_hold;
  logic [DATA_W-1:0] c_rdata_hold;

  // Reserved op 3 travels to memory as a NOP.
  function automatic logic [1:0] issue_op(input logic [1:0] op);
    return (op == OP_READ || op == OP_WRITE) ? op : OP_NOP;
  endfunction

  always_comb begin
    h_grant = 1'b0;
    c_grant = 1'b0;
    if (!i_rst) begin
      if (i_h_valid && (!i_c_valid || last_core)) h_grant = 1'b1;
      else if (i_c_valid)                          c_grant = 1'b1;
    end
  end

  assign xfer      = h_grant | c_grant;
  assign sel_op    = c_grant ? i_c_op    : i_h_op;
  assign sel_addr  = c_grant ? i_c_addr  : i_h_addr;
  assign sel_wdata = c_grant ? i_c_wdata : i_h_wdata;
  assign o_h_ready = h_grant;
  assign o_c_ready = c_grant;

  // Stage p0: accepted request becomes the registered memory command
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_core    <= 1'b1;
      mem_op_p0    <= OP_NOP;
      mem_addr_p0  <= '0;
      mem_wdata_p0 <= '0;
      vld_p0       <= 1'b0;
    end else begin
      mem_op_p0 <= xfer ? issue_op(sel_op) : OP_NOP;
      vld_p0    <= xfer && (sel_op == OP_READ);
      if (xfer) begin
        last_core    <= c_grant;
        mem_addr_p0  <= sel_addr;
        mem_wdata_p0 <= sel_wdata;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    own_core_p0 <= c_grant;
    own_core_p1 <= own_core_p0;
  end

  // Stage p1: memory read data is present; route it to the owner
  always_ff @(posedge i_clk) begin
    if (i_rst) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
  end

  assign o_h_rvalid = vld_p1 & ~own_core_p1 & ~i_rst;
  assign o_c_rvalid = vld_p1 &  own_core_p1 & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_rdata_hold <= '0;
      c_rdata_hold <= '0;
    end else begin
      if (o_h_rvalid) h_rdata_hold <= i_mem_rdata;
      if (o_c_rvalid) c_rdata_hold <= i_mem_rdata;
    end
  end

  assign o_h_rdata   = o_h_rvalid ? i_mem_rdata : h_rdata_hold;
  assign o_c_rdata   = o_c_rvalid ? i_mem_rdata : c_rdata_hold;
  // A command issued into a reset cycle is suppressed so memory never sees it.
  assign o_mem_op    = i_rst ? OP_NOP : mem_op_p0;
  assign o_mem_addr  = mem_addr_p0;
  assign o_mem_wdata = mem_wdata_p0;
  assign o_busy      = i_h_valid | i_c_valid | (~i_rst & (vld_p0 | vld_p1));

endmodule
